fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the single-issue RV32I pipeline. Owns the program
//   counter, drives the word-aligned address into the combinational-read instruction
//   memory, and captures the returned word plus PC into the IF/ID pipeline register.
//   Supports decode-stage stall, pipeline flush and branch/jump redirect.
// PARAMETERS
//   XLEN      32            data/address width
//   RESET_PC  32'h0000_0000 PC value loaded on reset (must be 4-byte aligned)
//   NOP_INSTR 32'h0000_0013 bubble instruction (addi x0,x0,0) placed in IF/ID
// PORTS
//   clk              in   1     rising-edge clock
//   rst              in   1     asynchronous, active-high reset
//   imem_addr        out  XLEN  byte address to instruction memory (== pc)
//   imem_rdata       in   32    instruction word, valid same cycle as imem_addr
//   stall_i          in   1     hold pc and IF/ID contents
//   flush_i          in   1     replace IF/ID contents with bubble
//   redirect_i       in   1     load pc from redirect_pc_i (taken branch/jump)
//   redirect_pc_i    in   XLEN  redirect target
//   if_id_valid      out  1     IF/ID holds a real instruction
//   if_id_instr      out  32    captured instruction
//   if_id_pc         out  XLEN  PC of captured instruction
//   if_id_pc_plus4   out  XLEN  if_id_pc + 4
//   misalign_o       out  1     one-cycle pulse: redirect target had [1:0] != 0
//   fetch_count      out  32    number of valid instructions captured (wraps)
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert): pc=RESET_PC, if_id_valid=0,
//     if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, misalign_o=0, fetch_count=0.
//   imem_addr = pc, combinational; pc[1:0] is always 2'b00.
//   Per clock edge, priority (highest first):
//   1 redirect_i: pc<=redirect_pc_i & ~3; IF/ID<=bubble (valid=0, instr=NOP_INSTR,
//     pc fields hold previous values); misalign_o<=|redirect_pc_i[1:0]. Overrides stall_i.
//   2 flush_i (no redirect): pc<=pc+4; IF/ID<=bubble. Overrides stall_i.
//   3 stall_i: pc and all IF/ID fields unchanged; fetch_count unchanged.
//   4 normal: IF/ID<={valid=1, instr=imem_rdata, pc, pc+4}; pc<=pc+4; fetch_count+=1.
//   misalign_o is 0 on every edge not taking case 1 (single-cycle pulse).
//   Latency: instruction at address A appears on if_id_* one edge after pc==A.
//   PC arithmetic modulo 2^XLEN: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
//   if_id_pc_plus4 wraps identically. fetch_count wraps 32'hFFFF_FFFF -> 0.
//   Reset asserted mid-stall or mid-redirect: all state to reset values immediately.
//   First edge after reset release fetches RESET_PC (no extra bubble cycle).
// STRUCTURE
//   Shared package riscv_pkg: XLEN, NOP_INSTR, RESET_PC default, if_id_t struct
//     {valid, instr, pc, pc_plus4}.
//   One sub-module: if_id_reg (IF/ID register with stall/flush/load controls,
//     async active-high reset); pc logic, misalign and counter stay in fetch_stage.
// TESTING
//   1 Reset, memfile words 0x00500093,0x00100113 at addr 0,4; run 2 edges ->
//     if_id_instr=0x00500093,pc=0, then 0x00100113,pc=4; fetch_count=2.
//   2 stall_i=1 for 3 edges at pc=8 -> imem_addr stays 8, IF/ID and count frozen;
//     release -> instr from addr 8 captured next edge.
//   3 redirect_i=1, redirect_pc_i=0x40 together with stall_i=1 -> next edge pc=0x40,
//     if_id_valid=0, if_id_instr=0x00000013; following edge captures word at 0x40.
//   4 redirect_pc_i=0x42 -> pc=0x40, misalign_o=1 for exactly one cycle.
//   5 flush_i=1 at pc=0x10 -> if_id_valid=0, pc=0x14; no count increment.
//   6 Redirect to 0xFFFFFFFC, run 2 edges -> if_id_pc=0xFFFFFFFC, pc_plus4=0,
//     next pc=0; assert rst mid-run -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: machine width, bubble encoding, reset vector,
// the IF/ID pipeline-register payload and the fetch-stage action decode.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    typedef enum logic [1:0] {
        FETCH_NORMAL,
        FETCH_STALL,
        FETCH_FLUSH,
        FETCH_REDIRECT
    } fetch_op_e;

    // Redirect beats flush, and both beat a decode-stage stall.
    function automatic fetch_op_e decode_fetch_op(
        input logic redirect,
        input logic flush,
        input logic stall
    );
        fetch_op_e op;
        if (redirect)   op = FETCH_REDIRECT;
        else if (flush) op = FETCH_FLUSH;
        else if (stall) op = FETCH_STALL;
        else            op = FETCH_NORMAL;
        return op;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble on flush, capture on load, otherwise hold.
// A bubble clears valid and instr only; the pc fields keep their last values.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] BUBBLE = riscv_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.valid    <= 1'b0;
            q.instr    <= BUBBLE;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the combinational imem and
// fills the IF/ID register, honouring redirect, flush and decode stall.
module fetch_stage #(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic            misalign_o,
    output logic [31:0]     fetch_count
);

    // PC is kept as a word index so the low two address bits are zero by construction.
    logic [XLEN-3:0]     pc_word;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;
    riscv_pkg::fetch_op_e op;
    riscv_pkg::if_id_t    if_id_d;
    riscv_pkg::if_id_t    if_id_q;
    logic                if_id_load;
    logic                if_id_flush;

    always_comb begin
        op       = riscv_pkg::decode_fetch_op(redirect_i, flush_i, stall_i);
        pc       = {pc_word, 2'b00};
        pc_plus4 = pc + XLEN'(4);
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_word <= RESET_PC[XLEN-1:2];
        end else begin
            unique case (op)
                riscv_pkg::FETCH_REDIRECT: pc_word <= redirect_pc_i[XLEN-1:2];
                riscv_pkg::FETCH_FLUSH,
                riscv_pkg::FETCH_NORMAL:   pc_word <= pc_word + 1'b1;
                default:                   pc_word <= pc_word;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= (op == riscv_pkg::FETCH_REDIRECT) && (|redirect_pc_i[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (op == riscv_pkg::FETCH_NORMAL) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        if_id_d.valid    = 1'b1;
        if_id_d.instr    = imem_rdata;
        if_id_d.pc       = pc;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_load       = (op == riscv_pkg::FETCH_NORMAL);
        if_id_flush      = (op == riscv_pkg::FETCH_REDIRECT) || (op == riscv_pkg::FETCH_FLUSH);
    end

    if_id_reg #(
        .BUBBLE (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (if_id_load),
        .flush (if_id_flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    always_comb begin
        if_id_valid    = if_id_q.valid;
        if_id_instr    = if_id_q.instr;
        if_id_pc       = if_id_q.pc;
        if_id_pc_plus4 = if_id_q.pc_plus4;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control
// traffic compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        misalign_o;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_cnt;
    logic        m_valid, m_mis;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .misalign_o     (misalign_o),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed program words, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[15:0] ^ 16'h1357, a[31:16] ^ a[15:0]} + 32'h0BAD_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic logic [161:0] dut_vec();
        return {imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, misalign_o, fetch_count};
    endfunction

    function automatic logic [161:0] mdl_vec();
        return {m_pc, m_valid, m_instr, m_ifpc, m_ifpc4, m_mis, m_cnt};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
        m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (redirect_i) begin
            m_pc    = {redirect_pc_i[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = 32'h13;
            m_mis   = redirect_pc_i[1:0] != 2'b00;
        end else if (flush_i) begin
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b0;
            m_instr = 32'h13;
        end else if (!stall_i) begin
            m_valid = 1'b1;
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic [31:0] rpc);
        redirect_i = r; flush_i = f; stall_i = s; redirect_pc_i = rpc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        redirect_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; redirect_pc_i = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), mdl_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_fetch();
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_instr !== 32'h0050_0093 || if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: got instr=%h pc=%h v=%b expected 00500093/0/1",
                     if_id_instr, if_id_pc, if_id_valid);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_instr !== 32'h0010_0113 || if_id_pc !== 32'h4 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL second_fetch: got instr=%h pc=%h cnt=%0d expected 00100113/4/2",
                     if_id_instr, if_id_pc, fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [161:0] frozen;
        frozen = dut_vec();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            n_checks++;
            if (imem_addr !== 32'h8 || dut_vec() !== mdl_vec() || mdl_vec() !== frozen) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_instr !== mem_word(32'h8) || if_id_pc !== 32'h8 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_release: got instr=%h pc=%h cnt=%0d expected %h/8/3",
                     if_id_instr, if_id_pc, fetch_count, mem_word(32'h8));
        end
    endtask

    task automatic test_redirect_over_stall();
        step(1'b1, 1'b0, 1'b1, 32'h40);
        n_checks++;
        if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 ||
            dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL redirect_stall: got %h expected %h", dut_vec(), mdl_vec());
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_instr !== mem_word(32'h40) || if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_capture: got instr=%h pc=%h expected %h/40",
                     if_id_instr, if_id_pc, mem_word(32'h40));
        end
    endtask

    task automatic test_misalign();
        step(1'b1, 1'b0, 1'b0, 32'h42);
        n_checks++;
        if (imem_addr !== 32'h40 || misalign_o !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_pulse: got addr=%h mis=%b expected 40/1", imem_addr, misalign_o);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (misalign_o !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL misalign_clear: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        step(1'b1, 1'b0, 1'b0, 32'h10);
        cnt_before = m_cnt;
        step(1'b0, 1'b1, 1'b1, '0);
        n_checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h14 || fetch_count !== cnt_before ||
            dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL flush: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_wrap_and_reset();
        step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h pc4=%h addr=%h expected fffffffc/0/0",
                     if_id_pc, if_id_pc_plus4, imem_addr);
        end
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h80;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), mdl_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0050_0093 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        logic        r, f, s;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                #3;
                rst = 1'b1;
                model_reset();
                #1;
                n_checks++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++;
                    $display("FAIL rand_reset[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            r   = ($urandom_range(0, 7) == 0);
            f   = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            step(r, f, s, rpc);
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_over_stall();
        test_misalign();
        test_flush();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
